minmax_stream: RTL and testbench
================================

# minmax_stream

Streaming min/max reducer that computes the minimum and maximum of a frame of W-bit samples arriving NI lanes per beat over a valid/ready stream. It reports both extremes with their positions in the frame. It extends the combinational NI-input min/max tree with:
- multi-beat frame accumulation,
- simultaneous min and max outputs,
- per-frame signed/unsigned mode,
- backpressured result delivery.

It sits between a sample source (ADC framer or DMA read stream) and a consumer of frame statistics.

## Interface
- W, 8, sample width in bits
- NI, 4, lanes (samples) per input beat; NI ≥ 1
- MAXBEATS, 16, maximum beats counted per frame; NI*MAXBEATS ≥ 2
- MM_CFG, 0, 0 = track min and max, 1 = min only, 2 = max only; untracked outputs are tied to 0
- IDXW, $clog2(NI*MAXBEATS), width of a frame sample index
- CNTW, $clog2(MAXBEATS+1), width of the beat count
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  input beat valid
- s_ready  output  1  block accepts a beat
- s_data  input  NI*W  lane k is s_data[W*(k+1)-1:W*k]
- s_last  input  1  beat is the final beat of the frame
- us_sel  input  1  0 = unsigned, 1 = signed compare; sampled on the first beat of each frame
- m_valid  output  1  frame result valid
- m_ready  input  1  consumer accepts the result
- m_min, m_max  output  W  frame minimum / maximum sample
- m_min_idx, m_max_idx  output  IDXW  frame index of the minimum / maximum
- m_count  output  CNTW  beats counted in the frame (saturates at MAXBEATS)
- m_trunc  output  1  frame exceeded MAXBEATS beats

## Operation
- A beat is accepted when s_valid && s_ready. Frame index of lane k on counted beat b is b*NI + k.
- Per-beat reduction is combinational over NI lanes:
  - Compares are signed or unsigned per the frame's latched mode.
  - Ties resolve to the lower lane.
- Beat results merge into the running accumulator. Ties resolve to the earlier (running) value, so the first occurrence in the frame wins for both min and max.
- The first beat of a frame (state ACC with beat counter 0) loads the accumulator directly and latches us_sel into the frame mode register. us_sel on later beats is ignored.
- Beats after MAXBEATS counted beats:
  - are accepted but excluded from the comparison;
  - leave the beat counter saturated at MAXBEATS;
  - set the trunc flag.
- State machine:
  - ACC: s_ready = 1, m_valid = 0. An accepted beat with s_last=1 moves to OUT; the final accumulator and counters are registered onto the m_* ports.
  - OUT: s_ready = 0, m_valid = 1, m_* stable. When m_ready = 1, go to ACC and clear the beat counter and trunc flag.
- A frame of exactly one beat is legal. There are no empty frames.
- m_valid is never asserted for a partial frame.

## Timing
- Reset (rst=1 at an edge) puts the block in ACC with:
  - m_valid=0, m_min=0, m_max=0, m_min_idx=0, m_max_idx=0, m_count=0, m_trunc=0;
  - beat counter 0, frame mode 0.
- s_ready is 0 in any cycle where rst=1.
- Reset mid-frame or during OUT discards all frame state and any pending result.
- Latency: m_valid rises on the edge that accepts the s_last beat, so results are visible in the next cycle.
- Throughput: one beat per cycle within a frame. There is exactly one bubble per frame, because s_ready=0 in the cycle where the result handshake completes. The next frame's first beat can be accepted in the cycle after the m_valid && m_ready cycle.
- While m_valid=1 && m_ready=0, all m_* outputs hold unchanged. m_valid does not drop without a handshake.
- s_data, s_last and us_sel are ignored when s_valid=0 or s_ready=0.
- The critical path is the NI-lane tree plus one accumulator compare. No internal pipelining.

## Test plan
All cases use W=8, NI=4, MAXBEATS=4, MM_CFG=0.

1. Unsigned single beat: lanes {5,200,5,17}, s_last=1, us_sel=0 -> next cycle m_valid=1, m_min=5 idx 0, m_max=200 idx 1, m_count=1, m_trunc=0.
2. Signed, same beat with us_sel=1 -> m_min=200 (0xC8 = -56) idx 1, m_max=17 idx 3. us_sel toggled on a second beat of a later frame has no effect on that frame.
3. Multi-beat with ties: beat0 {10,10,10,10}, beat1 {3,99,3,99} last -> m_min=3 idx 4, m_max=99 idx 5, m_count=2. With an all-equal frame {7,7,7,7} -> both idx 0.
4. Backpressure: hold m_ready=0 for 3 cycles after m_valid -> outputs stable, s_ready=0, a pending next-frame beat is not accepted. On m_ready=1 the beat is accepted in the following cycle and the new result is independent of the old.
5. Truncation: 6-beat frame, beats 0–3 in range 1..50, beat 4 contains 255 and 0 -> m_min/m_max come from beats 0–3 only, m_count=4, m_trunc=1. The next normal frame reports m_trunc=0.
6. Reset mid-frame: accept 2 beats, pulse rst for 1 cycle, then send single beat {9,8,7,6} last -> m_min=6 idx 3, m_max=9 idx 0, m_count=1. No result is ever issued for the aborted frame.

Source files
------------

// File: rtl/minmax_stream.sv
// Streaming min/max reducer: folds NI-lane beats of a frame into running extremes
// with first-occurrence positions, and presents one result per frame over valid/ready.
module minmax_stream #(
    parameter int W        = 8,
    parameter int NI       = 4,
    parameter int MAXBEATS = 16,
    parameter int MM_CFG   = 0,
    parameter int IDXW     = $clog2(NI*MAXBEATS),
    parameter int CNTW     = $clog2(MAXBEATS+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [NI*W-1:0] s_data,
    input  logic            s_last,
    input  logic            us_sel,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_min,
    output logic [W-1:0]    m_max,
    output logic [IDXW-1:0] m_min_idx,
    output logic [IDXW-1:0] m_max_idx,
    output logic [CNTW-1:0] m_count,
    output logic            m_trunc
);
    // state | meaning
    // ACC   | accepting beats, accumulating the current frame
    // OUT   | frame result presented, waiting for m_ready
    typedef enum logic {ACC, OUT} state_t;
    state_t state, state_nxt;

    logic [W-1:0]    lane [NI];
    logic            accept, first, counted, cmp_signed;
    logic            mode, trunc, trunc_nxt;
    logic [CNTW-1:0] beat_cnt, cnt_nxt;
    logic [W-1:0]    acc_min, acc_max, b_min, b_max, min_nxt, max_nxt;
    logic [IDXW-1:0] acc_min_idx, acc_max_idx, b_min_idx, b_max_idx, min_idx_nxt, max_idx_nxt;
    logic [W-1:0]    res_min, res_max;
    logic [IDXW-1:0] res_min_idx, res_max_idx;
    logic [CNTW-1:0] res_count;
    logic            res_trunc;

    function automatic logic lt(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        if (sgn) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    always_comb begin
        for (int k = 0; k < NI; k++) lane[k] = s_data[W*k +: W];
    end

    assign accept     = s_valid && s_ready;
    assign first      = (beat_cnt == '0);
    assign counted    = (beat_cnt != CNTW'(MAXBEATS));
    // the first beat compares in the mode it is about to latch
    assign cmp_signed = first ? us_sel : mode;

    // strict compares keep the lowest lane on ties
    always_comb begin : beat_tree
        int base;
        base      = int'(beat_cnt) * NI;
        b_min     = lane[0];
        b_max     = lane[0];
        b_min_idx = IDXW'(base);
        b_max_idx = IDXW'(base);
        for (int k = 1; k < NI; k++) begin
            if (lt(lane[k], b_min, cmp_signed)) begin
                b_min     = lane[k];
                b_min_idx = IDXW'(base + k);
            end
            if (lt(b_max, lane[k], cmp_signed)) begin
                b_max     = lane[k];
                b_max_idx = IDXW'(base + k);
            end
        end
    end

    always_comb begin : merge
        min_nxt     = acc_min;
        max_nxt     = acc_max;
        min_idx_nxt = acc_min_idx;
        max_idx_nxt = acc_max_idx;
        cnt_nxt     = beat_cnt;
        trunc_nxt   = trunc;
        if (first) begin
            min_nxt     = b_min;
            max_nxt     = b_max;
            min_idx_nxt = b_min_idx;
            max_idx_nxt = b_max_idx;
            cnt_nxt     = beat_cnt + CNTW'(1);
        end else if (counted) begin
            if (lt(b_min, acc_min, mode)) begin
                min_nxt     = b_min;
                min_idx_nxt = b_min_idx;
            end
            if (lt(acc_max, b_max, mode)) begin
                max_nxt     = b_max;
                max_idx_nxt = b_max_idx;
            end
            cnt_nxt = beat_cnt + CNTW'(1);
        end else begin
            trunc_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC: if (accept && s_last) state_nxt = OUT;
            OUT: if (m_ready)          state_nxt = ACC;
            default:                   state_nxt = ACC;
        endcase
    end

    always_comb begin
        s_ready = (state == ACC) && !rst;
        m_valid = (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_min     <= '0;
            acc_max     <= '0;
            acc_min_idx <= '0;
            acc_max_idx <= '0;
            beat_cnt    <= '0;
            trunc       <= 1'b0;
            mode        <= 1'b0;
            res_min     <= '0;
            res_max     <= '0;
            res_min_idx <= '0;
            res_max_idx <= '0;
            res_count   <= '0;
            res_trunc   <= 1'b0;
        end else begin
            if (accept) begin
                acc_min     <= min_nxt;
                acc_max     <= max_nxt;
                acc_min_idx <= min_idx_nxt;
                acc_max_idx <= max_idx_nxt;
                beat_cnt    <= cnt_nxt;
                trunc       <= trunc_nxt;
                if (first) mode <= us_sel;
                if (s_last) begin
                    res_min     <= min_nxt;
                    res_max     <= max_nxt;
                    res_min_idx <= min_idx_nxt;
                    res_max_idx <= max_idx_nxt;
                    res_count   <= cnt_nxt;
                    res_trunc   <= trunc_nxt;
                end
            end
            if (state == OUT && m_ready) begin
                beat_cnt <= '0;
                trunc    <= 1'b0;
            end
        end
    end

    assign m_min     = (MM_CFG == 2) ? '0 : res_min;
    assign m_min_idx = (MM_CFG == 2) ? '0 : res_min_idx;
    assign m_max     = (MM_CFG == 1) ? '0 : res_max;
    assign m_max_idx = (MM_CFG == 1) ? '0 : res_max_idx;
    assign m_count   = res_count;
    assign m_trunc   = res_trunc;
endmodule

// File: tb/tb_minmax_stream.sv
// Directed bench for minmax_stream: a frame-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_minmax_stream;
    localparam int W = 8, NI = 4, MAXBEATS = 4, MM_CFG = 0;
    localparam int IDXW = $clog2(NI*MAXBEATS), CNTW = $clog2(MAXBEATS+1);

    logic            clk = 0, rst = 1;
    logic            s_valid = 0, s_ready, s_last = 0, us_sel = 0;
    logic [NI*W-1:0] s_data = '0;
    logic            m_valid, m_ready = 0;
    logic [W-1:0]    m_min, m_max;
    logic [IDXW-1:0] m_min_idx, m_max_idx;
    logic [CNTW-1:0] m_count;
    logic            m_trunc;

    minmax_stream #(.W(W), .NI(NI), .MAXBEATS(MAXBEATS), .MM_CFG(MM_CFG)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .us_sel(us_sel), .m_valid(m_valid), .m_ready(m_ready),
        .m_min(m_min), .m_max(m_max), .m_min_idx(m_min_idx), .m_max_idx(m_max_idx),
        .m_count(m_count), .m_trunc(m_trunc));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    typedef struct {int mn; int mx; int mni; int mxi; int cnt; int tr;} res_t;
    res_t        exp_q[$];
    logic [7:0]  samples[$];
    int          nb = 0, tr = 0;
    bit          fmode = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    function automatic int sval(input logic [7:0] v, input bit sg);
        return sg ? int'($signed(v)) : int'(v);
    endfunction

    function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    // Reference model: keep the counted samples of the frame and scan them at the end.
    always @(negedge clk) begin
        if (rst) begin
            chk("s_ready_in_reset", int'(s_ready), 0);
            exp_q.delete();
            samples.delete();
            nb = 0;
            tr = 0;
        end else begin
            chk("m_valid", int'(m_valid), int'(exp_q.size() > 0));
            chk("s_ready", int'(s_ready), int'(exp_q.size() == 0));
            if (m_valid && exp_q.size() > 0) begin
                chk("m_min", int'(m_min), exp_q[0].mn);
                chk("m_max", int'(m_max), exp_q[0].mx);
                chk("m_min_idx", int'(m_min_idx), exp_q[0].mni);
                chk("m_max_idx", int'(m_max_idx), exp_q[0].mxi);
                chk("m_count", int'(m_count), exp_q[0].cnt);
                chk("m_trunc", int'(m_trunc), exp_q[0].tr);
                if (m_ready) void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                if (nb == 0) fmode = us_sel;
                if (nb < MAXBEATS) begin
                    for (int k = 0; k < NI; k++) samples.push_back(s_data[8*k +: 8]);
                    nb++;
                end else tr = 1;
                if (s_last) begin
                    res_t r;
                    int mni, mxi;
                    mni = 0;
                    mxi = 0;
                    for (int i = 1; i < samples.size(); i++) begin
                        if (sval(samples[i], fmode) < sval(samples[mni], fmode)) mni = i;
                        if (sval(samples[i], fmode) > sval(samples[mxi], fmode)) mxi = i;
                    end
                    r.mn = int'(samples[mni]);
                    r.mx = int'(samples[mxi]);
                    r.mni = mni;
                    r.mxi = mxi;
                    r.cnt = nb;
                    r.tr = tr;
                    exp_q.push_back(r);
                    samples.delete();
                    nb = 0;
                    tr = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit last, input bit us);
        int t;
        s_data = d;
        s_last = last;
        us_sel = us;
        s_valid = 1;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 50) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        step();
        s_valid = 0;
    endtask

    task automatic get_result(output res_t r);
        int t;
        m_ready = 1;
        t = 0;
        forever begin
            @(negedge clk);
            if (m_valid) break;
            t++;
            if (t > 50) begin
                chk("result_timeout", 1, 0);
                break;
            end
        end
        r.mn = int'(m_min);
        r.mx = int'(m_max);
        r.mni = int'(m_min_idx);
        r.mxi = int'(m_max_idx);
        r.cnt = int'(m_count);
        r.tr = int'(m_trunc);
        step();
        m_ready = 0;
    endtask

    task automatic lit(input string nm, input res_t r, input int mn, input int mni,
                       input int mx, input int mxi, input int cnt, input int trv);
        chk({nm, "_min"}, r.mn, mn);
        chk({nm, "_min_idx"}, r.mni, mni);
        chk({nm, "_max"}, r.mx, mx);
        chk({nm, "_max_idx"}, r.mxi, mxi);
        chk({nm, "_count"}, r.cnt, cnt);
        chk({nm, "_trunc"}, r.tr, trv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_min", int'(m_min), 0);
        chk("rst_m_max", int'(m_max), 0);
        chk("rst_m_idx", int'(m_min_idx) + int'(m_max_idx), 0);
        chk("rst_m_count", int'(m_count), 0);
        chk("rst_m_trunc", int'(m_trunc), 0);
        step();

        // unsigned single beat
        send(pk(5, 200, 5, 17), 1, 0);
        get_result(r);
        lit("t1", r, 5, 0, 200, 1, 1, 0);

        // signed single beat: 0xC8 = -56
        send(pk(5, 200, 5, 17), 1, 1);
        get_result(r);
        lit("t2", r, 200, 1, 17, 3, 1, 0);

        // us_sel asserted only on the second beat must not switch the frame to signed
        send(pk(1, 2, 3, 4), 0, 0);
        send(pk(128, 5, 6, 7), 1, 1);
        get_result(r);
        lit("t2b", r, 1, 0, 128, 4, 2, 0);

        // ties: first occurrence wins
        send(pk(10, 10, 10, 10), 0, 0);
        send(pk(3, 99, 3, 99), 1, 0);
        get_result(r);
        lit("t3", r, 3, 4, 99, 5, 2, 0);
        send(pk(7, 7, 7, 7), 1, 0);
        get_result(r);
        lit("t3b", r, 7, 0, 7, 0, 1, 0);

        // backpressure with a pending next-frame beat
        send(pk(40, 30, 20, 10), 1, 0);
        s_data = pk(1, 2, 3, 4);
        s_last = 1;
        us_sel = 0;
        s_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_m_valid", int'(m_valid), 1);
            chk("bp_s_ready", int'(s_ready), 0);
            chk("bp_m_min", int'(m_min), 10);
            chk("bp_m_max_idx", int'(m_max_idx), 0);
        end
        step();
        m_ready = 1;
        step();
        m_ready = 0;
        send(pk(1, 2, 3, 4), 1, 0);
        get_result(r);
        lit("t4", r, 1, 0, 4, 3, 1, 0);

        // truncation: beats 4 and 5 are excluded
        send(pk(10, 20, 30, 40), 0, 0);
        send(pk(2, 50, 25, 3), 0, 0);
        send(pk(11, 12, 13, 14), 0, 0);
        send(pk(5, 6, 7, 8), 0, 0);
        send(pk(255, 0, 9, 9), 0, 0);
        send(pk(100, 100, 100, 100), 1, 0);
        get_result(r);
        lit("t5", r, 2, 4, 50, 5, 4, 1);
        send(pk(1, 2, 3, 4), 1, 0);
        get_result(r);
        lit("t5b", r, 1, 0, 4, 3, 1, 0);

        // reset mid-frame discards the partial frame
        send(pk(1, 2, 3, 4), 0, 0);
        send(pk(0, 255, 0, 255), 0, 0);
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("t6_no_result", int'(m_valid), 0);
        step();
        send(pk(9, 8, 7, 6), 1, 0);
        get_result(r);
        lit("t6", r, 6, 3, 9, 0, 1, 0);

        repeat (3) step();
        chk("pending_results", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
